// File: rtl/dsram_pkg.sv
// Shared definitions for the data-SRAM responder.
//   state_e       : responder FSM states (IDLE, WAIT, RESP)
//   DSRAM_DATA_W  : word width of the array and data buses
//   DSRAM_BE_W    : number of byte-enable lanes per word
//   DSRAM_LAT_MAX : largest legal read latency
//   DSRAM_CNT_W   : width of the latency down-counter
package dsram_pkg;

  localparam int DSRAM_DATA_W  = 32;
  localparam int DSRAM_BE_W    = 4;
  localparam int DSRAM_LAT_MAX = 15;
  localparam int DSRAM_CNT_W   = $clog2(DSRAM_LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dsram_bytemem.sv
// Single-port byte-writable word array with a registered read port.
// Contents and the read register are not reset.
//   clk_i   : clock
//   addr_i  : word index shared by read and write
//   be_i    : per-byte write enables (all zero = no write)
//   wdata_i : write data, lanes matching be_i
//   rd_en_i : capture mem[addr_i] into the read register at this edge
//   rdata_o : read register, holds its value while rd_en_i is low
module dsram_bytemem
  import dsram_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic                    clk_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [DSRAM_BE_W-1:0]   be_i,
  input  logic [DSRAM_DATA_W-1:0] wdata_i,
  input  logic                    rd_en_i,
  output logic [DSRAM_DATA_W-1:0] rdata_o
);

  logic [DSRAM_DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DSRAM_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DSRAM_BE_W; b++) begin
      if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (rd_en_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-SRAM handshake. Reads complete with a
// one-cycle data_ok pulse READ_LAT cycles after acceptance; writes commit
// at the accepting edge.
// Optional build macro DSRAM_WRITE_ACK_EN: writes also follow the
// WAIT/RESP path and pulse data_ok once (rdata untouched).
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   data_sram_en       : request valid, held by the core until data_ok
//   data_sram_wen      : byte write enables (zero = read)
//   data_sram_addr     : byte address, word index = addr[ADDR_W+1:2]
//   data_sram_wdata    : write data
//   data_sram_rdata    : registered read data, held between responses
//   data_sram_data_ok  : single-cycle completion pulse
//   busy               : high while a response is pending (WAIT/RESP)
module data_sram_responder
  import dsram_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int READ_LAT = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    data_sram_en,
  input  logic [DSRAM_BE_W-1:0]   data_sram_wen,
  input  logic [31:0]             data_sram_addr,
  input  logic [DSRAM_DATA_W-1:0] data_sram_wdata,
  output logic [DSRAM_DATA_W-1:0] data_sram_rdata,
  output logic                    data_sram_data_ok,
  output logic                    busy
);

  localparam logic [DSRAM_CNT_W-1:0] LAT_LOAD = DSRAM_CNT_W'(READ_LAT - 1);

  state_e                  state_q, state_d;
  logic [DSRAM_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic                    rvalid_q;
  logic [ADDR_W-1:0]       req_idx;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_we;
  logic                    rd_en;
  logic [DSRAM_DATA_W-1:0] mem_rdata;
  logic                    unused_addr_bits;

  // Byte-offset bits and bits above the array size alias freely.
  assign req_idx          = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2]};

`ifdef DSRAM_WRITE_ACK_EN
  logic wr_q, wr_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mem_addr = idx_q;
    mem_we   = 1'b0;
    rd_en    = 1'b0;
`ifdef DSRAM_WRITE_ACK_EN
    wr_d     = wr_q;
`endif
    case (state_q)
      IDLE: begin
        // The array is addressed straight from the request so a READ_LAT=1
        // read lands in the read register at the accepting edge.
        mem_addr = req_idx;
        if (data_sram_en) begin
          if (data_sram_wen == '0) begin
            idx_d   = req_idx;
            cnt_d   = LAT_LOAD;
            state_d = (READ_LAT == 1) ? RESP : WAIT;
            rd_en   = (READ_LAT == 1);
`ifdef DSRAM_WRITE_ACK_EN
            wr_d    = 1'b0;
`endif
          end else begin
            mem_we = 1'b1;
`ifdef DSRAM_WRITE_ACK_EN
            idx_d   = req_idx;
            cnt_d   = LAT_LOAD;
            state_d = (READ_LAT == 1) ? RESP : WAIT;
            wr_d    = 1'b1;
`endif
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DSRAM_CNT_W'(1)) begin
          state_d = RESP;
`ifdef DSRAM_WRITE_ACK_EN
          rd_en   = ~wr_q;
`else
          rd_en   = 1'b1;
`endif
        end
      end
      // en is still held by the core here; ignoring it prevents double-issue.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (rd_en) rvalid_q <= 1'b1;
    end
  end

`ifdef DSRAM_WRITE_ACK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wr_q <= 1'b0;
    else         wr_q <= wr_d;
  end
`endif

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  dsram_bytemem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .addr_i  (mem_addr),
    .be_i    (mem_we ? data_sram_wen : '0),
    .wdata_i (data_sram_wdata),
    .rd_en_i (rd_en),
    .rdata_o (mem_rdata)
  );

  // The array read register has no reset; rvalid_q masks it to zero until
  // the first read after reset has loaded it.
  assign data_sram_rdata   = rvalid_q ? mem_rdata : '0;
  assign data_sram_data_ok = (state_q == RESP);
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic resetn;
  logic [1:0]       en    = '0;
  logic [1:0][3:0]  wen   = '0;
  logic [1:0][31:0] addr  = '0;
  logic [1:0][31:0] wdata = '0;
  wire  [1:0][31:0] rdata;
  wire  [1:0]       ok;
  wire  [1:0]       bsy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory: key = dut*65536 + word index.
  logic [31:0] model [int];

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(AW), .READ_LAT(1)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .data_sram_en(en[0]), .data_sram_wen(wen[0]), .data_sram_addr(addr[0]),
    .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
    .data_sram_data_ok(ok[0]), .busy(bsy[0])
  );

  data_sram_responder #(.ADDR_W(AW), .READ_LAT(4)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .data_sram_en(en[1]), .data_sram_wen(wen[1]), .data_sram_addr(addr[1]),
    .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
    .data_sram_data_ok(ok[1]), .busy(bsy[1])
  );

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int key(int d, logic [31:0] a);
    return d * 65536 + int'((a >> 2) & ((32'd1 << AW) - 1));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input string nm);
    logic [31:0] prev;
    int k;
    int c;
    prev = rdata[d];
    en[d] = 1'b1; wen[d] = be; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    k = key(d, a);
    model[k] = merge(model.exists(k) ? model[k] : 32'h0, wd, be);
    en[d] = 1'b0; wen[d] = '0;
`ifdef DSRAM_WRITE_ACK_EN
    c = 1;
    while (ok[d] !== 1'b1 && c < 20) begin
      @(posedge clk); #1; c++;
    end
    n_tests++;
    if (c != lat_of(d)) begin
      n_fail++; $display("FAIL %s wr_ack_latency: got %0d expected %0d", nm, c, lat_of(d));
    end
    n_tests++;
    if (rdata[d] !== prev) begin
      n_fail++; $display("FAIL %s wr_ack_rdata: got %h expected %h", nm, rdata[d], prev);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ok[d] !== 1'b0 || bsy[d] !== 1'b0) begin
      n_fail++; $display("FAIL %s wr_ack_end: ok=%b busy=%b expected 0 0", nm, ok[d], bsy[d]);
    end
`else
    c = 0;
    n_tests++;
    if (ok[d] !== 1'b0 || bsy[d] !== 1'b0) begin
      n_fail++; $display("FAIL %s wr_silent: ok=%b busy=%b expected 0 0 (c=%0d)", nm, ok[d], bsy[d], c);
    end
`endif
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input string nm,
                         output logic [31:0] got);
    logic [31:0] prev;
    logic [31:0] exp_v;
    int c;
    int k;
    prev = rdata[d];
    k = key(d, a);
    exp_v = model.exists(k) ? model[k] : 32'hx;
    en[d] = 1'b1; wen[d] = '0; addr[d] = a;
    @(posedge clk); #1;
    c = 1;
    while (ok[d] !== 1'b1 && c < 20) begin
      n_tests++;
      if (rdata[d] !== prev) begin
        n_fail++; $display("FAIL %s rdata_hold: got %h expected %h", nm, rdata[d], prev);
      end
      @(posedge clk); #1; c++;
    end
    got = rdata[d];
    n_tests++;
    if (c != lat_of(d)) begin
      n_fail++; $display("FAIL %s rd_latency: got %0d expected %0d", nm, c, lat_of(d));
    end
    n_tests++;
    if (rdata[d] !== exp_v || bsy[d] !== 1'b1) begin
      n_fail++; $display("FAIL %s rd_data: got %h busy=%b expected %h busy=1", nm, rdata[d], bsy[d], exp_v);
    end
    // en stays high through the data_ok cycle, as the core does.
    @(posedge clk); #1;
    en[d] = 1'b0;
    n_tests++;
    if (ok[d] !== 1'b0 || bsy[d] !== 1'b0 || rdata[d] !== exp_v) begin
      n_fail++; $display("FAIL %s rd_single_pulse: ok=%b busy=%b rdata=%h expected 0 0 %h",
                         nm, ok[d], bsy[d], rdata[d], exp_v);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (ok[d] !== 1'b0 || bsy[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        n_fail++; $display("FAIL reset_state dut%0d: ok=%b busy=%b rdata=%h expected 0 0 0",
                           d, ok[d], bsy[d], rdata[d]);
      end
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] g;
    do_write(0, 32'h100, 32'hDEADBEEF, 4'hF, "basic");
    do_read(0, 32'h100, "basic", g);
    n_tests++;
    if (g !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_value: got %h expected deadbeef", g);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] g;
    do_write(0, 32'h200, 32'h11223344, 4'hF, "lanes");
    do_write(0, 32'h200, 32'h000000AA, 4'h1, "lanes");
    do_write(0, 32'h200, 32'hBB000000, 4'h8, "lanes");
    do_read(0, 32'h200, "lanes", g);
    n_tests++;
    if (g !== 32'hBB2233AA) begin
      n_fail++; $display("FAIL lanes_value: got %h expected bb2233aa", g);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    logic [31:0] v [3] = '{32'hA0A0A0A0, 32'h5B5B5B5B, 32'hC3C3C3C3};
    for (int i = 0; i < 3; i++) do_write(1, 32'(4 * i), v[i], 4'hF, "b2b");
    for (int i = 0; i < 3; i++) begin
      do_read(1, 32'(4 * i), "b2b", g);
      n_tests++;
      if (g !== v[i]) begin
        n_fail++; $display("FAIL b2b_value%0d: got %h expected %h", i, g, v[i]);
      end
    end
  endtask

  task automatic test_alias();
    logic [31:0] g;
    do_write(0, 32'h0001_0004, 32'h12345678, 4'hF, "alias");
    do_read(0, 32'h0000_0004, "alias", g);
    n_tests++;
    if (g !== 32'h12345678) begin
      n_fail++; $display("FAIL alias_value: got %h expected 12345678", g);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] g;
    bit pulsed;
    do_write(1, 32'h300, 32'h0F1E2D3C, 4'hF, "rstmid");
    en[1] = 1'b1; wen[1] = '0; addr[1] = 32'h300;
    @(posedge clk); #1;
    n_tests++;
    if (bsy[1] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_busy: got %b expected 1", bsy[1]);
    end
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (ok[1] !== 1'b0 || bsy[1] !== 1'b0 || rdata[1] !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_async: ok=%b busy=%b rdata=%h expected 0 0 0", ok[1], bsy[1], rdata[1]);
    end
    pulsed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ok[1] !== 1'b0) pulsed = 1'b1;
    end
    en[1] = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ok[1] !== 1'b0) pulsed = 1'b1;
    end
    n_tests++;
    if (pulsed) begin
      n_fail++; $display("FAIL rstmid_no_pulse: got pulse expected none");
    end
    do_read(1, 32'h300, "rstmid_after", g);
    n_tests++;
    if (g !== 32'h0F1E2D3C) begin
      n_fail++; $display("FAIL rstmid_value: got %h expected 0f1e2d3c", g);
    end
  endtask

  task automatic test_random();
    logic [31:0] g;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        a = ($urandom & 32'hFFFF_0003) | (32'(12'h040 + i) << 2);
        do_write(d, a, $urandom, 4'hF, "rnd_fill");
      end
      for (int n = 0; n < 50; n++) begin
        a = ($urandom & 32'hFFFF_0003) | (32'(12'h040 + $urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 1) == 0)
          do_write(d, a, $urandom, 4'($urandom_range(1, 15)), "rnd");
        else
          do_read(d, a, "rnd", g);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_back_to_back();
    test_alias();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
